// File: rtl/inv_rcon_ctrl.sv
// inv_rcon_ctrl
// -------------
// Emits the AES round constants in reverse order for the decryption key
// schedule. The schedule starts from the last round key and works back to the
// cipher key. Each step divides the current constant by x in GF(2^8):
// 0x36, 0x1B, 0x80, 0x40 ... 0x01.
//
// Ports
//   ClkxCI          clock, rising edge
//   RstxBI          asynchronous reset, active low
//   StartxSI        load START_RCON / NUM_RCON and enter RUN (wins over Next)
//   NextxSI         advance to the previous round constant (RUN only)
//   ActivexSI       gates the constant onto RCONxDO
//   RCONxDO         current constant when RUN and ActivexSI, else 0x00
//   RoundxDO        round counter NUM_RCON..1 while RUN, else 0
//   BusyxSO         FSM in RUN
//   FirstRoundxSO   RUN and round == NUM_RCON
//   PenultRoundxSO  RUN and round == 2
//   LastRoundxSO    RUN and round == 1
//   FinishedxSO     FSM in DONE (level until the next Start)
//   StatexDO        raw FSM state, for debug and checker binding
//
// Handshake: Start and Next are single-cycle strobes sampled on the rising
// clock edge. There is no back-pressure. The outputs reflect a sampled strobe
// one cycle later. All outputs decode registers only, except the ActivexSI
// gate on RCONxDO.
module inv_rcon_ctrl #(
  parameter int          NUM_RCON   = 10,
  parameter logic [7:0]  START_RCON = 8'h36
) (
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       StartxSI,
  input  logic       NextxSI,
  input  logic       ActivexSI,
  output logic [7:0] RCONxDO,
  output logic [3:0] RoundxDO,
  output logic       BusyxSO,
  output logic       FirstRoundxSO,
  output logic       PenultRoundxSO,
  output logic       LastRoundxSO,
  output logic       FinishedxSO,
  output logic [1:0] StatexDO
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [3:0] NumRconC = 4'(NUM_RCON);

  state_t     StatexDP, StatexDN;
  logic [7:0] RCONxDP, RCONxDN;
  logic [3:0] RoundxDP, RoundxDN;

  // Division by x in GF(2^8) modulo 0x11B. When the low bit is set, the
  // reduction polynomial is added before the shift: (b ^ 0x11B) >> 1
  // equals (b >> 1) ^ 0x8D.
  function automatic logic [7:0] invStep(input logic [7:0] b);
    if (b[0]) return (b >> 1) ^ 8'h8D;
    else      return b >> 1;
  endfunction

  // State register
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP <= IDLE;
      RCONxDP  <= START_RCON;
      RoundxDP <= NumRconC;
    end else begin
      StatexDP <= StatexDN;
      RCONxDP  <= RCONxDN;
      RoundxDP <= RoundxDN;
    end
  end

  // Next-state logic
  always_comb begin
    StatexDN = StatexDP;
    RCONxDN  = RCONxDP;
    RoundxDN = RoundxDP;
    case (StatexDP)
      IDLE, DONE: begin
        if (StartxSI) begin
          StatexDN = RUN;
          RCONxDN  = START_RCON;
          RoundxDN = NumRconC;
        end
      end
      RUN: begin
        if (StartxSI) begin
          RCONxDN  = START_RCON;
          RoundxDN = NumRconC;
        end else if (NextxSI) begin
          if (RoundxDP > 4'd1) begin
            RCONxDN  = invStep(RCONxDP);
            RoundxDN = RoundxDP - 4'd1;
          end else begin
            // Last constant consumed: the registers are preloaded so that
            // DONE/IDLE never hold a partially walked sequence.
            StatexDN = DONE;
            RCONxDN  = START_RCON;
            RoundxDN = NumRconC;
          end
        end
      end
      ILLEGAL: begin
        StatexDN = IDLE;
        RCONxDN  = START_RCON;
        RoundxDN = NumRconC;
      end
      default: begin
        StatexDN = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    BusyxSO        = (StatexDP == RUN);
    FinishedxSO    = (StatexDP == DONE);
    RCONxDO        = (BusyxSO && ActivexSI) ? RCONxDP : 8'h00;
    RoundxDO       = BusyxSO ? RoundxDP : 4'd0;
    FirstRoundxSO  = BusyxSO && (RoundxDP == NumRconC);
    PenultRoundxSO = BusyxSO && (RoundxDP == 4'd2);
    LastRoundxSO   = BusyxSO && (RoundxDP == 4'd1);
    StatexDO       = StatexDP;
  end

endmodule

// File: doc/inv_rcon_ctrl.md
Name: inv_rcon_ctrl

Overview:
- Generates the AES round constant (RCON) sequence in reverse order for the decryption-side key schedule, which rolls the last round key back to the cipher key.
- Steps by GF(2^8) division by x: 0x36, 0x1B, 0x80, 0x40 ... 0x01.
- Small FSM with start/step handshake. Exports round number and round-position flags to the decryption datapath controller.

Parameters:
- NUM_RCON, 10, number of RCON values per key (10 for AES-128); legal range 1..10.
- START_RCON, 8'h36, first constant emitted; must equal forward RCON[NUM_RCON] (10 -> 0x36).

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- StartxSI  in  1  load START_RCON, round := NUM_RCON, enter RUN.
- NextxSI  in  1  advance to previous round constant.
- ActivexSI  in  1  gate RCON onto RCONxDO.
- RCONxDO  out  8  current RCON when RUN and ActivexSI, else 0x00.
- RoundxDO  out  4  current round counter (NUM_RCON down to 1); 0 when not RUN.
- BusyxSO  out  1  FSM in RUN.
- FirstRoundxSO  out  1  RUN and round == NUM_RCON.
- PenultRoundxSO  out  1  RUN and round == 2.
- LastRoundxSO  out  1  RUN and round == 1.
- FinishedxSO  out  1  FSM in DONE.

Behaviour:
- Registers: 2-bit state, RCONxDP[7:0], RoundxDP[3:0]. All outputs are combinational decodes of registers only; no input-to-output path except the ActivexSI gating on RCONxDO.
- Reset (async, RstxBI=0):
  - state := IDLE, RCONxDP := START_RCON, RoundxDP := NUM_RCON.
  - Outputs: RCONxDO=0x00, RoundxDO=0, BusyxSO=0, all flags 0, FinishedxSO=0.
- Inverse step inv(b): if b[0]=0 then b>>1, else (b>>1) ^ 0x8D.
  - Examples: 0x1B->0x80, 0x02->0x01, 0x01->0x8D.
- State IDLE:
  - StartxSI=1: load START_RCON / NUM_RCON, go to RUN next cycle.
  - NextxSI is ignored.
- State RUN:
  - StartxSI=1: reload START_RCON / NUM_RCON and stay in RUN. Start takes priority over a simultaneous Next.
  - Else NextxSI=1 and round>1: RCONxDP := inv(RCONxDP), RoundxDP := RoundxDP-1.
  - Else NextxSI=1 and round==1: go to DONE. RCONxDP and RoundxDP reload START_RCON / NUM_RCON.
  - No Next: hold all registers.
- State DONE:
  - FinishedxSO=1 as a level until StartxSI.
  - StartxSI=1 -> RUN with a fresh load. NextxSI is ignored.
- Latency: one cycle from a Start/Next edge-sample to the updated RCONxDO / RoundxDO / flags.
- Flags:
  - FirstRoundxSO and LastRoundxSO are both 1 when NUM_RCON=1.
  - PenultRoundxSO never asserts when NUM_RCON=1.
- Illegal state encoding (4th code) returns to IDLE on the next clock.
- Reset mid-RUN aborts immediately; no partial state survives.
- With ActivexSI=0, RCONxDO=0x00 regardless of state; the sequence still advances.

Test Plan:
- Reset, then Start pulse, then 10 Next pulses with ActivexSI=1 -> RCONxDO = 36,1B,80,40,20,10,08,04,02,01; RoundxDO = 10..1; FirstRoundxSO on 0x36, PenultRoundxSO on 0x02, LastRoundxSO on 0x01. After the 10th Next, FinishedxSO=1, BusyxSO=0, RCONxDO=0x00.
- Mid-sequence restart: after 3 Next pulses (RCON 0x40), assert Start and Next together -> next cycle RCON=0x36, Round=10, BusyxSO=1.
- Next pulses in IDLE and in DONE -> no change; RoundxDO=0, RCONxDO=0x00, FinishedxSO holds 1 in DONE.
- ActivexSI=0 during RUN with 4 Next pulses -> RCONxDO=0x00 throughout; raise ActivexSI -> 0x20 shown, Round=6.
- Async reset asserted mid-cycle at round 5 (RCON 0x10) -> outputs zero immediately without a clock edge; after release, Start yields 0x36.
- Parameter build NUM_RCON=8, START_RCON=8'h80 (AES-192) -> sequence 80,40,20,10,08,04,02,01, then DONE after the 8th Next.
